// File: rtl/chan_mux_scan_if.sv
// Channel-selector bus: packed channel inputs and scan controls going in, registered channel view coming out.
// The source of din/controls uses the master modport and the selector uses the slave modport.
interface chan_mux_scan_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] din;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic                      hold;
    logic                      inv;
    logic [WIDTH-1:0]          y;
    logic [SEL_W-1:0]          ch;
    logic                      ch_chg;

    modport master (
        output din, mode, sel, hold, inv,
        input  y, ch, ch_chg
    );

    modport slave (
        input  din, mode, sel, hold, inv,
        output y, ch, ch_chg
    );
endinterface

// File: rtl/chan_mux_scan.sv
// Registered N-channel selector with optional inversion; the channel comes from sel or from a
// round-robin scan that dwells DWELL cycles per channel. Every output is taken straight from a flop.
//
// state  | meaning
// MANUAL | channel follows sel (an out-of-range sel keeps the current channel), dwell counter at 0
// AUTO   | round-robin scan; the first edge after entering AUTO only clears the dwell counter
module chan_mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_mux_scan_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q;
    logic             ch_chg_q;
    logic             sel_ok;
    logic [WIDTH-1:0] chan [2**SEL_W];

    // Pad the channel table to a power of two so any index is in range; padded slots are never selected.
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_chan
        if (k < CHANNELS) begin : g_valid
            assign chan[k] = bus.din[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    assign sel_ok = (int'(bus.sel) < CHANNELS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= MANUAL;
            ch_q     <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            ch_chg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            y_q      <= bus.inv ? ~chan[ch_d] : chan[ch_d];
            ch_chg_q <= (ch_d != ch_q);
        end
    end

    always_comb begin
        state_d = state_e'(bus.mode);
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        if (!bus.hold) begin
            case (state_d)
                MANUAL: begin
                    cnt_d = '0;
                    if (sel_ok) begin
                        ch_d = bus.sel;
                    end
                end
                AUTO: begin
                    if (state_q == MANUAL) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        ch_d  = (ch_q == CH_LAST) ? '0 : ch_q + SEL_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    ch_d  = ch_q;
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    assign bus.y      = y_q;
    assign bus.ch     = ch_q;
    assign bus.ch_chg = ch_chg_q;
endmodule
